// File: rtl/alu_mdu.sv
// alu_mdu: handshaked XLEN-bit integer ALU with an optional iterative multiply/divide unit.
// Define ALU_MDU_MULDIV_EN to build the mul/div datapath; otherwise opcodes 0x10-0x17 return 0.
module alu_mdu #(
    parameter int unsigned  XLEN = 32,
    localparam int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] w_alu;
    logic [SHW-1:0]  w_shamt;
    logic            w_hs, w_is_md, w_md_done;
    logic [XLEN-1:0] w_md_res;

    assign w_hs    = in_valid & in_ready & ~kill;
    assign w_shamt = in_b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (in_op)
            5'h00:   w_alu = in_a + in_b;
            5'h01:   w_alu = in_a - in_b;
            5'h02:   w_alu = in_a & in_b;
            5'h03:   w_alu = in_a | in_b;
            5'h04:   w_alu = in_a ^ in_b;
            5'h05:   w_alu = in_a << w_shamt;
            5'h06:   w_alu = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            5'h07:   w_alu = {{(XLEN-1){1'b0}}, in_a < in_b};
            5'h08:   w_alu = in_a >> w_shamt;
            5'h09:   w_alu = $unsigned($signed(in_a) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_MDU_MULDIV_EN
    logic [XLEN-1:0]   r_a, r_b, r_acc;
    logic [SHW-1:0]    r_cnt;
    logic [2:0]        r_op;
    logic              r_negq, r_negr;
    logic              w_a_sgn, w_b_sgn;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_acc_nxt, w_b_nxt;
    logic [XLEN:0]     w_sum, w_rsh, w_diff;
    logic [2*XLEN-1:0] w_prod;

    assign w_is_md   = (in_op[4:3] == 2'b10);
    assign w_md_done = (r_state == StBusy) && (r_cnt == SHW'(XLEN-1));
    // Signed operands: mulh/mulhsu take signed a, mulh signed b; div/rem take both signed.
    assign w_a_sgn   = in_a[XLEN-1] & (in_op[2] ? ~in_op[0] : (in_op[1] ^ in_op[0]));
    assign w_b_sgn   = in_b[XLEN-1] & (in_op[2] ? ~in_op[0] : (in_op[1:0] == 2'b01));
    assign w_a_mag   = w_a_sgn ? ('0 - in_a) : in_a;
    assign w_b_mag   = w_b_sgn ? ('0 - in_b) : in_b;

    // One iteration: shift-add multiply into {acc, b}, or restoring divide with quotient in b.
    always_comb begin
        w_sum  = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
        w_rsh  = {r_acc, r_b[XLEN-1]};
        w_diff = w_rsh - {1'b0, r_a};
        if (!r_op[2]) begin
            w_acc_nxt = w_sum[XLEN:1];
            w_b_nxt   = {w_sum[0], r_b[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
            w_acc_nxt = w_diff[XLEN-1:0];
            w_b_nxt   = {r_b[XLEN-2:0], 1'b1};
        end else begin
            w_acc_nxt = w_rsh[XLEN-1:0];
            w_b_nxt   = {r_b[XLEN-2:0], 1'b0};
        end
        w_prod = {w_acc_nxt, w_b_nxt};
        if (r_negq) w_prod = '0 - w_prod;
        w_md_res = '0;
        case (r_op)
            3'd0:             w_md_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_md_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_md_res = r_negq ? ('0 - w_b_nxt) : w_b_nxt;
            default:          w_md_res = r_negr ? ('0 - w_acc_nxt) : w_acc_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_op   <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
        end else if (w_hs && w_is_md) begin
            r_a    <= in_op[2] ? w_b_mag : w_a_mag;
            r_b    <= in_op[2] ? w_a_mag : w_b_mag;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_op   <= in_op[2:0];
            // Divide by zero keeps an unsigned all-ones quotient.
            r_negq <= (w_a_sgn ^ w_b_sgn) & (~in_op[2] | (|in_b));
            r_negr <= w_a_sgn;
        end else if (r_state == StBusy) begin
            r_acc <= w_acc_nxt;
            r_b   <= w_b_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy = (r_state == StBusy);
`else
    assign w_is_md   = 1'b0;
    assign w_md_done = 1'b0;
    assign w_md_res  = '0;
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (w_hs && !w_is_md) begin
            r_result <= w_alu;
        end else if (w_md_done) begin
            r_result <= w_md_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_hs)                                 w_state_nxt = w_is_md ? StBusy : StDone;
                    else if (r_state == StDone && out_ready) w_state_nxt = StIdle;
                end
                StBusy:  if (w_md_done) w_state_nxt = StDone;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
        out_valid = (r_state == StDone);
    end

    assign out_result = r_result;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu; directed corner cases plus randomized ops
// checked against an arithmetic reference model. Follows ALU_MDU_MULDIV_EN like the RTL.
module tb_alu_mdu;
    localparam int unsigned XLEN = 32;
`ifdef ALU_MDU_MULDIV_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 0;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0]        p;
        int                 sh, ia, ib;
        sh = int'(b[4:0]);
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a & b;
            5'h03: return a | b;
            5'h04: return a ^ b;
            5'h05: return a << sh;
            5'h06: return (ia < ib) ? 32'd1 : 32'd0;
            5'h07: return (a < b) ? 32'd1 : 32'd0;
            5'h08: return a >> sh;
            5'h09: begin p = sa >>> sh; return p[31:0]; end
            default: ;
        endcase
        if (!MdEn || op[4:3] != 2'b10) return 32'd0;
        case (op[2:0])
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // out_ready follows rdy_mode: 0 = high, 1 = low, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin : monitor
        txn_t t;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", out_result, 32'hxxxx_xxxx);
            end else begin
                t = exp_q.pop_front();
                check($sformatf("op%02h a=%h b=%h", t.op, t.a, t.b), out_result, t.res);
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input bit scramble);
        bit   acc = 1'b0;
        txn_t t;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !kill;
            @(posedge clk);
            #2;
            if (!acc && scramble) begin
                in_a = rnd();
                in_b = rnd();
            end
        end
        check("issue_accepted", 32'(acc), 32'd1);
        if (acc && push) begin
            t.op = op; t.a = in_a; t.b = in_b; t.res = model(op, in_a, in_b);
            exp_q.push_back(t);
        end
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    task automatic directed(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        txn_t t;
        issue(op, a, b, 1'b0, 1'b0);
        t.op = op; t.a = a; t.b = b; t.res = exp;
        exp_q.push_back(t);
    endtask

    task automatic lat_check(input string name, input int exp_lat, input int exp_busy);
        int cyc = 0;
        int nbusy = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            seen = out_valid;
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
        #2;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_result"}, out_result, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  md_lat;
        int  md_busy;
        bit  seen;
        logic [4:0] op;
        int  k;
        md_lat  = MdEn ? XLEN + 1 : 1;
        md_busy = MdEn ? XLEN : 0;

        repeat (3) @(posedge clk);
        #2;
        reset_values("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        reset_values("after_reset");
        @(posedge clk);
        #2;

        directed(5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        lat_check("add", 1, 0);
        directed(5'h09, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000);
        lat_check("sra", 1, 0);
        directed(5'h12, 32'hFFFF_FFFF, 32'h0000_0002, MdEn ? 32'hFFFF_FFFF : 32'd0);
        lat_check("mulhsu", md_lat, md_busy);
        directed(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, MdEn ? 32'h8000_0000 : 32'd0);
        directed(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        directed(5'h15, 32'd7, 32'd0, MdEn ? 32'hFFFF_FFFF : 32'd0);
        directed(5'h17, 32'd7, 32'd0, MdEn ? 32'd7 : 32'd0);
        directed(5'h10, 32'd3, 32'd4, MdEn ? 32'd12 : 32'd0);
        lat_check("mul", md_lat, md_busy);
        drain();

        // Held result under back-pressure, then release with a same-cycle new op.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        directed(5'h04, 32'h0F0F_0F0F, 32'h0000_0000, 32'h0F0F_0F0F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_result", out_result, 32'h0F0F_0F0F);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        rdy_mode = 0;
        directed(5'h01, 32'd5, 32'd7, 32'hFFFF_FFFE);
        lat_check("sub", 1, 0);
        drain();

        // kill beats a same-cycle in_valid.
        in_valid = 1'b1;
        in_op    = 5'h00;
        in_a     = 32'd1;
        in_b     = 32'd2;
        kill     = 1'b1;
        @(posedge clk);
        #2;
        kill     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("kill_vs_valid_out_valid", 32'(out_valid), 32'd0);
        check("kill_vs_valid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // kill drops a pending result held by back-pressure.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        issue(5'h00, 32'd9, 32'd9, 1'b0, 1'b0);
        kill = 1'b1;
        @(posedge clk);
        #2;
        kill = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("kill_pending_out_valid", 32'(out_valid), 32'd0);
        check("kill_pending_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

`ifdef ALU_MDU_MULDIV_EN
        // kill lands on BUSY cycle 10 of a multiply.
        issue(5'h10, rnd(), rnd(), 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        kill = 1'b1;
        @(posedge clk);
        #2;
        kill = 1'b0;
        @(negedge clk);
        check("kill_busy_busy", 32'(busy), 32'd0);
        check("kill_busy_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("kill_busy_no_out_valid", 32'(seen), 32'd0);
        @(posedge clk);
        #2;
`endif

        // Asynchronous reset in the middle of a divide.
        rdy_mode = 1;
        @(posedge clk);
        #2;
        issue(5'h14, 32'h1234_5678, 32'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_values("async_reset");
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        rdy_mode = 0;
        exp_q.delete();
        @(posedge clk);
        #2;

        rdy_mode = 2;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 18);
            if (k < 10)      op = 5'(k);
            else if (k < 18) op = 5'(k + 6);
            else             op = ($urandom_range(0, 1) != 0) ? 5'h0C : 5'h1D;
            issue(op, rnd(), rnd(), 1'b1, 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #2;
            end
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked execution unit for the RISC-V core: XLEN-wide integer ALU plus an iterative RV32M/RV64M-style multiply/divide unit. It accepts one operation at a time over a valid/ready interface, returns a registered result, and replaces the purely combinational ALU in the pipelined core's execute stage. Single-cycle ops take one cycle; multiply/divide ops take XLEN+1 cycles.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN): shift-amount width (derived, not overridden).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation this cycle.
- in_op  input  5  operation code (encoding below).
- in_a, in_b  input  XLEN  operands.
- kill  input  1  synchronous flush; drops any in-flight or pending result.
- out_valid  output  1  out_result holds a completed result.
- out_ready  input  1  consumer takes the result.
- out_result  output  XLEN  result, registered.
- busy  output  1  iterative mul/div in progress.

## Operation
- Opcodes 0x00 to 0x09: add, sub, and, or, xor, sll, slt, sltu, srl, sra. 0x10 to 0x17: mul, mulh, mulhsu, mulhu, div, divu, rem, remu. Any other code yields result 0 via the single-cycle path.
- Shifts use in_b[SHW-1:0] only; upper bits ignored.
- slt/sltu produce 1 or 0, zero-extended.
- mul returns the low XLEN bits. mulh/mulhsu/mulhu return the high XLEN bits of the 2·XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Division truncates toward zero. Remainder takes the dividend's sign.
- Divide by zero: quotient all ones; remainder equals the dividend.
- Signed overflow (MIN / −1): quotient MIN; remainder 0.
- FSM states:
  - IDLE → DONE on handshake with a single-cycle op.
  - IDLE → BUSY on handshake with a mul/div op; operands are latched, with magnitudes and sign flags captured for signed ops.
  - BUSY holds for exactly XLEN cycles, processing 1 bit per cycle (shift-add multiply, restoring divide), then → DONE with the sign-corrected result.
  - DONE → IDLE on out_ready with no new handshake. DONE → DONE or BUSY on out_ready plus a same-cycle new handshake.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- busy = (state==BUSY).
- kill: next state is IDLE and out_valid drops the next cycle. kill beats a same-cycle in_valid, which is not accepted and must be re-offered.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, busy 0, in_ready 1. Iteration counter and datapath registers are 0.
- Single-cycle op accepted at edge N: out_valid=1 and out_result valid after edge N.
- Mul/div accepted at edge N: busy is 1 after edges N through N+XLEN−1; out_valid=1 after edge N+XLEN.
- out_result and out_valid hold stable while out_valid & !out_ready.
- Back-to-back single-cycle ops with out_ready held high: one result per cycle.
- rst_n low mid-iteration: immediate return to reset values; the partial result is discarded.
- Operands may change freely while in_ready=0. They are sampled only on the handshake edge.

## Configuration
- ALU_MDU_MULDIV_EN defined: mul/div datapath, BUSY state and counter are compiled in, as above.
- Not defined: opcodes 0x10 to 0x17 complete on the single-cycle path with result 0, busy is tied 0, and the BUSY state is never entered.

## Test plan
- Reset, then add 0x7FFFFFFF + 1 → out_valid one cycle later with 0x80000000. Then sra 0x80000000 by in_b=0x21 → 0xC0000000, since the shift uses the low 5 bits (=1).
- mulhsu 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF. busy is high for 32 cycles; out_valid appears 33 edges after acceptance.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000. rem with the same operands → 0. divu 7 / 0 → 0xFFFFFFFF. remu 7 / 0 → 7.
- out_ready held 0 for 5 cycles after an xor result of 0x0F0F0F0F: result stable and in_ready=0. Then out_ready=1 with a new sub 5 − 7 in the same cycle → 0xFFFFFFFE on the next cycle.
- kill asserted at BUSY cycle 10 of a mul: next cycle is IDLE, out_valid never rises, and in_ready=1. rst_n pulsed low mid-div: all outputs return to reset values asynchronously.
- Build without ALU_MDU_MULDIV_EN: mul 3 × 4 → 0 one cycle later, and busy never asserts.
